// File: rtl/sh_mtu.sv
// sh_mtu: multi-channel 16/32-bit timer unit with prescaler, external count
// clocks, compare A/B with output actions, clear/reload and SR/IER interrupts.
// Optional compare buffers BRA/BRB are built when SH_MTU_BUFFER_EN is defined.
module sh_mtu #(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic [3:0]    tclk_i,
    input  logic [6:0]    addr_i,
    input  logic [31:0]   wdata_i,
    input  logic          we_i,
    input  logic          req_i,
    output logic [31:0]   rdata_o,
    output logic [CH-1:0] tioca_o,
    output logic [CH-1:0] tiocb_o,
    output logic [CH-1:0] imia_irq_o,
    output logic [CH-1:0] imib_irq_o,
    output logic [CH-1:0] ovi_irq_o
);

`ifdef SH_MTU_BUFFER_EN
    localparam logic [11:0] CR_MASK = 12'hFFF;
`else
    localparam logic [11:0] CR_MASK = 12'hF3F;
`endif

    logic [5:0]    psc_q;
    logic [3:0]    tclk_q, ext_tick_q;
    logic [CH-1:0] str_q, str_d;
    logic [CH-1:0] tioca_q, tioca_d, tiocb_q, tiocb_d;
    logic [11:0]   cr_q   [CH];
    logic [11:0]   cr_d   [CH];
    logic [W-1:0]  tcnt_q [CH];
    logic [W-1:0]  tcnt_d [CH];
    logic [W-1:0]  gra_q  [CH];
    logic [W-1:0]  gra_d  [CH];
    logic [W-1:0]  grb_q  [CH];
    logic [W-1:0]  grb_d  [CH];
`ifdef SH_MTU_BUFFER_EN
    logic [W-1:0]  bra_q  [CH];
    logic [W-1:0]  bra_d  [CH];
    logic [W-1:0]  brb_q  [CH];
    logic [W-1:0]  brb_d  [CH];
`endif
    logic [3:0]    sr_q   [CH];
    logic [3:0]    sr_d   [CH];
    logic [3:0]    ier_q  [CH];
    logic [3:0]    ier_d  [CH];
    logic [3:0]    set_c  [CH];
    logic [CH-1:0] tick_c, ma_c, mb_c, wr_c;
    logic [31:0]   rdata_q, rd_c;

    logic [3:0] blk_c, ch_sel_c;
    logic [2:0] reg_sel_c;
    logic       ch_hit_c, bus_wr_c, bus_rd_c;
    logic       unused_wdata;

    assign blk_c     = addr_i[6:3];
    assign ch_sel_c  = blk_c - 4'd1;
    assign reg_sel_c = addr_i[2:0];
    assign ch_hit_c  = (blk_c != 4'd0) && (blk_c <= 4'(CH));
    assign bus_wr_c  = req_i & we_i;
    assign bus_rd_c  = req_i & ~we_i;
    assign unused_wdata = ^wdata_i;

    // Count tick source select: internal divider taps or registered ext edge.
    function automatic logic sel_tick(input logic [2:0] tpsc, input logic [5:0] psc,
                                      input logic [3:0] ext);
        if (tpsc[2]) return ext[tpsc[1:0]];
        case (tpsc[1:0])
            2'd0:    return 1'b1;
            2'd1:    return &psc[1:0];
            2'd2:    return &psc[3:0];
            default: return &psc;
        endcase
    endfunction

    // Compare-match output action.
    function automatic logic apply_oc(input logic cur, input logic [1:0] mode);
        case (mode)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~cur;
            default: return cur;
        endcase
    endfunction

    // Next state for every channel: tick/compare effects first, bus write on top.
    always_comb begin
        str_d   = str_q;
        tioca_d = tioca_q;
        tiocb_d = tiocb_q;
        if (bus_wr_c && addr_i == 7'd0) str_d = wdata_i[CH-1:0];
        for (int i = 0; i < CH; i++) begin
            cr_d[i]   = cr_q[i];
            tcnt_d[i] = tcnt_q[i];
            gra_d[i]  = gra_q[i];
            grb_d[i]  = grb_q[i];
`ifdef SH_MTU_BUFFER_EN
            bra_d[i]  = bra_q[i];
            brb_d[i]  = brb_q[i];
`endif
            ier_d[i]  = ier_q[i];
            set_c[i]  = 4'b0;
            tick_c[i] = str_q[i] & sel_tick(cr_q[i][2:0], psc_q, ext_tick_q);
            ma_c[i]   = (tcnt_q[i] == gra_q[i]);
            mb_c[i]   = (tcnt_q[i] == grb_q[i]);
            wr_c[i]   = bus_wr_c & ch_hit_c & (ch_sel_c == 4'(i));

            if (tick_c[i]) begin
                if (ma_c[i]) begin
                    set_c[i][0] = 1'b1;
                    tioca_d[i]  = apply_oc(tioca_q[i], cr_q[i][9:8]);
`ifdef SH_MTU_BUFFER_EN
                    if (cr_q[i][6]) gra_d[i] = bra_q[i];
`endif
                end
                if (mb_c[i]) begin
                    set_c[i][1] = 1'b1;
                    tiocb_d[i]  = apply_oc(tiocb_q[i], cr_q[i][11:10]);
`ifdef SH_MTU_BUFFER_EN
                    if (cr_q[i][7]) grb_d[i] = brb_q[i];
`endif
                end
                if (!cr_q[i][5]) begin
                    if ((cr_q[i][4:3] == 2'b01 && ma_c[i]) ||
                        (cr_q[i][4:3] == 2'b10 && mb_c[i])) begin
                        tcnt_d[i] = '0;
                    end else begin
                        tcnt_d[i] = tcnt_q[i] + W'(1);
                        if (&tcnt_q[i]) set_c[i][2] = 1'b1;
                    end
                end else if (tcnt_q[i] == '0) begin
                    set_c[i][3] = 1'b1;
                    tcnt_d[i]   = (cr_q[i][4:3] == 2'b01) ? gra_q[i] : '1;
                end else begin
                    tcnt_d[i] = tcnt_q[i] - W'(1);
                end
            end

            if (wr_c[i]) begin
                case (reg_sel_c)
                    3'd0: cr_d[i]   = wdata_i[11:0] & CR_MASK;
                    3'd1: tcnt_d[i] = wdata_i[W-1:0];
                    3'd2: gra_d[i]  = wdata_i[W-1:0];
                    3'd3: grb_d[i]  = wdata_i[W-1:0];
`ifdef SH_MTU_BUFFER_EN
                    3'd4: bra_d[i]  = wdata_i[W-1:0];
                    3'd5: brb_d[i]  = wdata_i[W-1:0];
`endif
                    3'd7: ier_d[i]  = wdata_i[3:0];
                    default: ;
                endcase
            end
            sr_d[i] = (sr_q[i] & ~((wr_c[i] && reg_sel_c == 3'd6) ? wdata_i[3:0] : 4'b0))
                      | set_c[i];
        end
    end

    // Read mux; absent channels and unmapped words return 0.
    always_comb begin
        rd_c = '0;
        if (addr_i == 7'd0) rd_c = 32'(str_q);
        for (int i = 0; i < CH; i++) begin
            if (ch_hit_c && ch_sel_c == 4'(i)) begin
                case (reg_sel_c)
                    3'd0: rd_c = 32'(cr_q[i]);
                    3'd1: rd_c = 32'(tcnt_q[i]);
                    3'd2: rd_c = 32'(gra_q[i]);
                    3'd3: rd_c = 32'(grb_q[i]);
`ifdef SH_MTU_BUFFER_EN
                    3'd4: rd_c = 32'(bra_q[i]);
                    3'd5: rd_c = 32'(brb_q[i]);
`endif
                    3'd6: rd_c = 32'(sr_q[i]);
                    3'd7: rd_c = 32'(ier_q[i]);
                    default: rd_c = '0;
                endcase
            end
        end
    end

    // State registers; reset overrides CE, CE low freezes everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psc_q      <= '0;
            tclk_q     <= '0;
            ext_tick_q <= '0;
            str_q      <= '0;
            tioca_q    <= '0;
            tiocb_q    <= '0;
            rdata_q    <= '0;
            for (int i = 0; i < CH; i++) begin
                cr_q[i]   <= '0;
                tcnt_q[i] <= '0;
                gra_q[i]  <= '1;
                grb_q[i]  <= '1;
`ifdef SH_MTU_BUFFER_EN
                bra_q[i]  <= '1;
                brb_q[i]  <= '1;
`endif
                sr_q[i]   <= '0;
                ier_q[i]  <= '0;
            end
        end else if (ce_i) begin
            psc_q      <= psc_q + 6'd1;
            tclk_q     <= tclk_i;
            ext_tick_q <= tclk_i & ~tclk_q;
            str_q      <= str_d;
            tioca_q    <= tioca_d;
            tiocb_q    <= tiocb_d;
            if (bus_rd_c) rdata_q <= rd_c;
            for (int i = 0; i < CH; i++) begin
                cr_q[i]   <= cr_d[i];
                tcnt_q[i] <= tcnt_d[i];
                gra_q[i]  <= gra_d[i];
                grb_q[i]  <= grb_d[i];
`ifdef SH_MTU_BUFFER_EN
                bra_q[i]  <= bra_d[i];
                brb_q[i]  <= brb_d[i];
`endif
                sr_q[i]   <= sr_d[i];
                ier_q[i]  <= ier_d[i];
            end
        end
    end

    // Interrupt requests follow SR and IER directly.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            imia_irq_o[i] = sr_q[i][0] & ier_q[i][0];
            imib_irq_o[i] = sr_q[i][1] & ier_q[i][1];
            ovi_irq_o[i]  = (sr_q[i][2] & ier_q[i][2]) | (sr_q[i][3] & ier_q[i][3]);
        end
    end

    assign rdata_o = rdata_q;
    assign tioca_o = tioca_q;
    assign tiocb_o = tiocb_q;

endmodule

// File: tb/tb_sh_mtu.sv
// Scoreboard bench for sh_mtu: reads push expected data, the read-data
// monitor pops and compares one cycle later; pin checks go through check().
`timescale 1ns/1ps
module tb_sh_mtu;
    localparam int unsigned CH = 4;
    localparam int unsigned W  = 16;
    localparam int R_CR = 0, R_TCNT = 1, R_GRA = 2, R_GRB = 3;
    localparam int R_BRA = 4, R_SR = 6, R_IER = 7;

    logic          clk = 1'b0;
    logic          rst, ce, we, req;
    logic [3:0]    tclk;
    logic [6:0]    addr;
    logic [31:0]   wdata, rdata;
    logic [CH-1:0] tioca, tiocb, imia, imib, ovi;

    int          n_vec = 0;
    int          n_bad = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic        rd_vld = 1'b0;

    sh_mtu #(.CH(CH), .W(W)) dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .tclk_i(tclk), .addr_i(addr),
        .wdata_i(wdata), .we_i(we), .req_i(req), .rdata_o(rdata),
        .tioca_o(tioca), .tiocb_o(tiocb), .imia_irq_o(imia),
        .imib_irq_o(imib), .ovi_irq_o(ovi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Read-data monitor: one result per read issued in the previous cycle.
    always @(posedge clk) rd_vld <= req & ~we & ~rst;
    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check(tag_q.pop_front(), rdata, exp_q.pop_front());
        end
    end

    function automatic logic [6:0] ra(input int ch, input int r);
        return 7'(8 * (ch + 1) + r);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        cyc(1);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, input logic [31:0] e, input string tag);
        req = 1'b1; we = 1'b0; addr = a;
        tag_q.push_back(tag); exp_q.push_back(e);
        cyc(1);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ce = 1'b1; tclk = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        cyc(2);
        rst = 1'b0;

        // Reset state
        check("rst_tioca", 32'(tioca), 32'd0);
        check("rst_irq", 32'({imia, imib, ovi}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rd(7'd0, 32'd0, "rst_str");
        rd(ra(0, R_CR), 32'd0, "rst_cr");
        rd(ra(0, R_TCNT), 32'd0, "rst_tcnt");
        rd(ra(0, R_GRA), 32'h0000FFFF, "rst_gra");
        rd(ra(0, R_GRB), 32'h0000FFFF, "rst_grb");
`ifdef SH_MTU_BUFFER_EN
        rd(ra(0, R_BRA), 32'h0000FFFF, "rst_bra");
`else
        rd(ra(0, R_BRA), 32'd0, "rst_bra_absent");
`endif
        rd(ra(0, R_SR), 32'd0, "rst_sr");
        wr(7'd7, 32'hFFFFFFFF);
        rd(7'd7, 32'd0, "unmapped_rd");
        wr(ra(CH, R_GRA), 32'h1234);
        rd(ra(CH, R_GRA), 32'd0, "absent_ch_rd");

        // Count up, clear on A, toggle TIOCA
        wr(ra(0, R_CR), 32'h308);
        wr(ra(0, R_GRA), 32'd5);
        wr(7'd0, 32'd1);
        for (int k = 0; k < 7; k++) begin
            rd(ra(0, R_TCNT), (k < 6) ? 32'(k) : 32'd0, "clrA_tcnt");
            check("clrA_tioca", 32'(tioca[0]), (k >= 5) ? 32'd1 : 32'd0);
        end
        cyc(4);
        check("clrA_tioca_hold", 32'(tioca[0]), 32'd1);
        cyc(1);
        check("clrA_tioca_toggle", 32'(tioca[0]), 32'd0);
        rd(ra(0, R_SR), 32'd1, "clrA_imfa");
        wr(ra(0, R_IER), 32'd1);
        check("clrA_imia_irq", 32'(imia[0]), 32'd1);
        wr(7'd0, 32'd0);
        wr(ra(0, R_SR), 32'hF);
        rd(ra(0, R_SR), 32'd0, "sr_w1c");
        check("sr_w1c_irq", 32'(imia[0]), 32'd0);

        // Overflow, W1C, set-wins-over-clear, bus collision
        wr(ra(1, R_GRA), 32'h1000);
        wr(ra(1, R_GRB), 32'h1000);
        wr(ra(1, R_TCNT), 32'hFFFE);
        wr(7'd0, 32'd2);
        rd(ra(1, R_SR), 32'd0, "ovf_t0");
        rd(ra(1, R_SR), 32'd0, "ovf_t1");
        rd(ra(1, R_SR), 32'd4, "ovf_set");
        wr(ra(1, R_SR), 32'd4);
        rd(ra(1, R_SR), 32'd0, "ovf_clr");
        wr(ra(1, R_TCNT), 32'hFFFF);
        wr(ra(1, R_SR), 32'd4);
        rd(ra(1, R_SR), 32'd4, "ovf_set_wins");
        check("ovi_masked", 32'(ovi[1]), 32'd0);
        wr(ra(1, R_IER), 32'd4);
        check("ovi_enabled", 32'(ovi[1]), 32'd1);
        wr(ra(1, R_TCNT), 32'h100);
        rd(ra(1, R_TCNT), 32'h100, "collide_tcnt");
        rd(ra(1, R_TCNT), 32'h101, "collide_next");
        wr(7'd0, 32'd0);

        // Down count with auto-reload from GRA
        wr(ra(2, R_CR), 32'h28);
        wr(ra(2, R_GRA), 32'd3);
        wr(ra(2, R_GRB), 32'h1000);
        wr(ra(2, R_TCNT), 32'd1);
        wr(ra(2, R_IER), 32'd8);
        wr(7'd0, 32'd4);
        rd(ra(2, R_TCNT), 32'd1, "down_1");
        rd(ra(2, R_TCNT), 32'd0, "down_0");
        rd(ra(2, R_TCNT), 32'd3, "down_reload");
        rd(ra(2, R_TCNT), 32'd2, "down_2");
        rd(ra(2, R_SR), 32'd9, "down_sr");
        check("down_ovi", 32'(ovi[2]), 32'd1);
        check("down_imia_masked", 32'(imia[2]), 32'd0);
        wr(ra(2, R_IER), 32'd0);
        check("down_ovi_off", 32'(ovi[2]), 32'd0);
        wr(7'd0, 32'd0);

        // Buffered compare on channel 3
        wr(ra(3, R_CR), 32'h48);
        wr(ra(3, R_GRA), 32'd4);
        wr(ra(3, R_BRA), 32'd9);
        wr(ra(3, R_GRB), 32'h1000);
        wr(ra(3, R_TCNT), 32'd0);
        wr(7'd0, 32'd8);
        for (int k = 0; k < 16; k++) begin
`ifdef SH_MTU_BUFFER_EN
            rd(ra(3, R_TCNT), (k < 5) ? 32'(k) : 32'((k - 5) % 10), "buf_tcnt");
`else
            rd(ra(3, R_TCNT), 32'(k % 5), "nobuf_tcnt");
`endif
        end
        wr(7'd0, 32'd0);
`ifdef SH_MTU_BUFFER_EN
        rd(ra(3, R_GRA), 32'd9, "buf_gra");
        rd(ra(3, R_BRA), 32'd9, "buf_bra");
        rd(ra(3, R_CR), 32'h48, "buf_cr");
`else
        rd(ra(3, R_GRA), 32'd4, "nobuf_gra");
        rd(ra(3, R_BRA), 32'd0, "nobuf_bra");
        rd(ra(3, R_CR), 32'h08, "nobuf_cr");
`endif

        // External clock TCLK[1]
        wr(ra(0, R_CR), 32'h5);
        wr(ra(0, R_TCNT), 32'd0);
        wr(7'd0, 32'd1);
        for (int n = 0; n < 3; n++) begin
            tclk = 4'b0010;
            rd(ra(0, R_TCNT), 32'(n), "ext_edge");
            rd(ra(0, R_TCNT), 32'(n), "ext_tick");
            rd(ra(0, R_TCNT), 32'(n + 1), "ext_inc");
            tclk = 4'b0000;
            cyc(1);
        end
        rd(ra(0, R_TCNT), 32'd3, "ext_total");

        // Clock enable freezes counting
        wr(ra(0, R_CR), 32'h0);
        wr(ra(0, R_TCNT), 32'd0);
        ce = 1'b0;
        cyc(3);
        ce = 1'b1;
        rd(ra(0, R_TCNT), 32'd0, "ce_hold");
        rd(ra(0, R_TCNT), 32'd1, "ce_resume");

        // Reset mid-count
        wr(ra(0, R_CR), 32'h200);
        wr(ra(0, R_GRA), 32'd2);
        wr(ra(0, R_TCNT), 32'd0);
        wr(ra(0, R_IER), 32'd1);
        cyc(4);
        check("pre_rst_tioca", 32'(tioca[0]), 32'd1);
        check("pre_rst_imia", 32'(imia[0]), 32'd1);
        rd(ra(0, R_GRA), 32'd2, "pre_rst_gra");
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_rst_outs", 32'({tioca, tiocb, imia, imib, ovi}), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        rd(ra(0, R_GRA), 32'h0000FFFF, "mid_rst_gra");
        rd(ra(0, R_TCNT), 32'd0, "mid_rst_tcnt");
        rd(7'd0, 32'd0, "mid_rst_str");

        cyc(2);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
